// File: rtl/generador_direcciones_escritura_if.sv
// rtl/generador_direcciones_escritura_if.sv - write-beat bus between address generator and filter-output memory
interface generador_direcciones_escritura_if #(
    parameter int ANCHO_DIR = 16,
    parameter int ANCHO_IDX = 2
);
    logic [ANCHO_DIR-1:0] dir_escritura;
    logic                 we_mem;
    logic [ANCHO_IDX-1:0] indice_dato;
    logic                 listo_mem;

    modport master (
        output dir_escritura,
        output we_mem,
        output indice_dato,
        input  listo_mem
    );

    modport slave (
        input  dir_escritura,
        input  we_mem,
        input  indice_dato,
        output listo_mem
    );
endinterface

// File: rtl/generador_direcciones_escritura.sv
// rtl/generador_direcciones_escritura.sv - write-address generator and burst sequencer (option: VERIFICACION_PROTOCOLO_EN)
module generador_direcciones_escritura #(
    parameter int          ANCHO_DIR          = 16,
    parameter int unsigned DIR_INICIAL        = 0,
    parameter int unsigned DIR_LIMITE         = 32'h4000,
    parameter int unsigned PASO_FILA          = 64,
    parameter int unsigned PASO_COLUMNA       = 3,
    parameter int unsigned COLS_POR_FILA      = 4,
    parameter int unsigned ESCRITURAS_POR_COL = 3,
    localparam int         ANCHO_IDX          = (ESCRITURAS_POR_COL > 1) ? $clog2(ESCRITURAS_POR_COL) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic guardar_fila_base,
    input  logic aumentar_fila_base,
    input  logic actualizar_dir_columna,
    input  logic habilitar_cuenta_col,
    input  logic reiniciar_conteo_cols,
    input  logic escribir_mem,
    generador_direcciones_escritura_if.master mem,
    output logic escrituras_completadas,
    output logic columnas_completadas,
    output logic fin_imagen,
    output logic error_protocolo
);
    localparam int ANCHO_CNT = $clog2(COLS_POR_FILA + 1);

    typedef enum logic {REPOSO, RAFAGA} estado_t;

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] fila_base_q, fila_base_d;
    logic [ANCHO_DIR-1:0] dir_columna_q, dir_columna_d;
    logic [ANCHO_CNT-1:0] conteo_cols_q, conteo_cols_d;
    logic [ANCHO_IDX-1:0] beat_q, beat_d;
    logic                 fin_imagen_q, fin_imagen_d;
    logic [ANCHO_DIR:0]   suma_fila;
    logic                 ocupado;
    logic                 ultimo_beat;

    assign ocupado     = (estado_q == RAFAGA);
    assign ultimo_beat = (beat_q == ANCHO_IDX'(ESCRITURAS_POR_COL - 1));
    // Extra carry bit so a base near the top of the address space cannot wrap silently.
    assign suma_fila   = {1'b0, fila_base_q} + (ANCHO_DIR + 1)'(PASO_FILA);

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q      <= REPOSO;
            fila_base_q   <= ANCHO_DIR'(DIR_INICIAL);
            dir_columna_q <= ANCHO_DIR'(DIR_INICIAL);
            conteo_cols_q <= '0;
            beat_q        <= '0;
            fin_imagen_q  <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            fila_base_q   <= fila_base_d;
            dir_columna_q <= dir_columna_d;
            conteo_cols_q <= conteo_cols_d;
            beat_q        <= beat_d;
            fin_imagen_q  <= fin_imagen_d;
        end
    end

    always_comb begin
        estado_d               = estado_q;
        beat_d                 = beat_q;
        fila_base_d            = fila_base_q;
        dir_columna_d          = dir_columna_q;
        conteo_cols_d          = conteo_cols_q;
        fin_imagen_d           = 1'b0;
        escrituras_completadas = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (escribir_mem) begin
                    estado_d = RAFAGA;
                    beat_d   = '0;
                end
            end
            RAFAGA: begin
                if (mem.listo_mem) begin
                    if (ultimo_beat) begin
                        escrituras_completadas = 1'b1;
                        estado_d               = REPOSO;
                        beat_d                 = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: estado_d = REPOSO;
        endcase

        if (aumentar_fila_base) begin
            if (suma_fila >= (ANCHO_DIR + 1)'(DIR_LIMITE)) begin
                fila_base_d  = ANCHO_DIR'(DIR_INICIAL);
                fin_imagen_d = 1'b1;
            end else begin
                fila_base_d = suma_fila[ANCHO_DIR-1:0];
            end
        end

        // Loading the column pointer always reads the base as it was before this edge.
        if (guardar_fila_base) begin
            dir_columna_d = fila_base_q;
        end else if (actualizar_dir_columna) begin
            dir_columna_d = dir_columna_q + ANCHO_DIR'(PASO_COLUMNA);
        end

        if (reiniciar_conteo_cols) begin
            conteo_cols_d = '0;
        end else if (habilitar_cuenta_col && (conteo_cols_q != ANCHO_CNT'(COLS_POR_FILA))) begin
            conteo_cols_d = conteo_cols_q + 1'b1;
        end
    end

    assign mem.dir_escritura = dir_columna_q + ANCHO_DIR'(beat_q);
    assign mem.we_mem        = ocupado;
    assign mem.indice_dato   = beat_q;
    assign columnas_completadas = (conteo_cols_q == ANCHO_CNT'(COLS_POR_FILA));
    assign fin_imagen           = fin_imagen_q;

`ifdef VERIFICACION_PROTOCOLO_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if (ocupado && (escribir_mem || actualizar_dir_columna ||
                                 guardar_fila_base || aumentar_fila_base)) begin
            error_q <= 1'b1;
        end
    end

    assign error_protocolo = error_q;
`else
    assign error_protocolo = 1'b0;
`endif

endmodule
